sd_spi_card_responder: RTL and testbench

// - Card-side end of the SD SPI-mode link: models an SDHC card answering the host init sequence.
// - Samples sd_cclk/sd_cmd (MOSI)/sd_cs from the host; drives sd_data0 (MISO).
// - Used as the bench/loopback partner for the SD SPI host, and exposes decoded commands for logging over UART.

---
 rtl/sd_spi_pkg.sv | 46 ++++
 rtl/sd_crc7.sv | 30 +++
 rtl/sd_spi_card_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared SD SPI-mode definitions: command indices, R1 layout, response widths,
// card FSM states and the CRC7 step used by both ends of the link.
package sd_spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;
    localparam int R1_CRC_ERR_BIT = 3;

    localparam logic [5:0] R1_W    = 6'd8;
    localparam logic [5:0] R7_W    = 6'd40;
    localparam logic [5:0] R3_W    = 6'd40;
    localparam logic [5:0] FRAME_W = 6'd48;

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_RX     = 3'd1,
        S_DECODE = 3'd2,
        S_NCR    = 3'd3,
        S_TX     = 3'd4
    } sd_state_e;

    // One serial step of CRC7 (x^7 + x^3 + 1), data MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // Build an R1 byte; a CRC error masks the illegal-command flag.
    function automatic logic [7:0] make_r1(input logic crc_err, input logic illegal,
                                           input logic idle);
        logic [7:0] r1;
        r1 = 8'h00;
        r1[R1_CRC_ERR_BIT] = crc_err;
        r1[R1_ILLEGAL_BIT] = illegal & ~crc_err;
        r1[R1_IDLE_BIT]    = idle;
        return r1;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator: clear has priority over shift.
module sd_crc7
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_r;

    // CRC register: cleared between frames, advanced once per received bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= 7'h00;
        end else if (clr) begin
            crc_r <= 7'h00;
        end else if (shift_en) begin
            crc_r <= crc7_step(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/sd_spi_card_responder.sv
// Card side of the SD SPI link: answers the SDHC init sequence and reports
// every accepted command frame.
module sd_spi_card_responder
    import sd_spi_pkg::*;
#(
    parameter int          NCR_BYTES  = 1,
    parameter int          IDLE_POLLS = 2,
    parameter int          CHECK_CRC  = 1,
    parameter logic [31:0] OCR_READY  = 32'hC0FF8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_cclk,
    input  logic        sd_cmd,
    input  logic        sd_cs,
    output logic        sd_data0,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        in_idle
);

    localparam int             PW        = (IDLE_POLLS < 2) ? 1 : $clog2(IDLE_POLLS + 1);
    localparam logic [PW-1:0]  POLL_INIT = PW'(IDLE_POLLS);
    localparam logic [5:0]     NCR_LAST  = 6'(NCR_BYTES * 8 - 1);

    logic cclk_meta_r, cclk_sync_r, cclk_prev_r;
    logic cmd_meta_r, cmd_sync_r, cs_meta_r, cs_sync_r;
    logic rise_s, fall_s;

    sd_state_e      state_r, state_s;
    logic           hunt_zero_r, hunt_zero_s;
    logic [5:0]     bit_cnt_r, bit_cnt_s, tx_len_r, tx_len_s;
    logic [5:0]     tx_cnt_r, tx_cnt_s, ncr_cnt_r, ncr_cnt_s;
    logic [47:0]    rx_sr_r, rx_sr_s;
    logic [39:0]    tx_sr_r, tx_sr_s;
    logic [PW-1:0]  poll_cnt_r, poll_cnt_s, poll_dec_s;
    logic           spi_mode_r, spi_mode_s, app_flag_r, app_flag_s;
    logic           in_idle_r, in_idle_s, cmd_valid_r, cmd_valid_s, miso_r, miso_s;
    logic [5:0]     cmd_index_r, cmd_index_s;
    logic [31:0]    cmd_arg_r, cmd_arg_s;
    logic           crc_clr_s, crc_shift_s;
    logic [6:0]     crc_val_s;

    logic [5:0]     frame_idx_s;
    logic [31:0]    frame_arg_s, ocr_s;
    logic           frame_ok_s, crc_err_s, acmd_idle_s;

    // Bring the host-side pins into the clk domain and keep the previous clock level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cclk_meta_r <= 1'b0;
            cclk_sync_r <= 1'b0;
            cclk_prev_r <= 1'b0;
            cmd_meta_r  <= 1'b1;
            cmd_sync_r  <= 1'b1;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
        end else begin
            cclk_meta_r <= sd_cclk;
            cclk_sync_r <= cclk_meta_r;
            cclk_prev_r <= cclk_sync_r;
            cmd_meta_r  <= sd_cmd;
            cmd_sync_r  <= cmd_meta_r;
            cs_meta_r   <= sd_cs;
            cs_sync_r   <= cs_meta_r;
        end
    end

    // Edges only count while the card is selected.
    assign rise_s = cclk_sync_r & ~cclk_prev_r & ~cs_sync_r;
    assign fall_s = ~cclk_sync_r & cclk_prev_r & ~cs_sync_r;

    // Received CRC covers the start bit through the last argument bit.
    sd_crc7 u_crc7 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (crc_clr_s),
        .shift_en (crc_shift_s),
        .din      (cmd_sync_r),
        .crc      (crc_val_s)
    );

    assign frame_idx_s = rx_sr_r[45:40];
    assign frame_arg_s = rx_sr_r[39:8];
    assign frame_ok_s  = (rx_sr_r[47:46] == 2'b01) && rx_sr_r[0];
    assign crc_err_s   = (CHECK_CRC != 0) && ((frame_idx_s == CMD0) || (frame_idx_s == CMD8))
                         && (crc_val_s != rx_sr_r[7:1]);
    assign ocr_s       = {OCR_READY[31] & ~in_idle_r, OCR_READY[30:0]};
    assign poll_dec_s  = (poll_cnt_r == PW'(0)) ? PW'(0) : (poll_cnt_r - PW'(1));
    assign acmd_idle_s = (poll_dec_s == PW'(0)) ? 1'b0 : in_idle_r;

    // Next-state and datapath updates for hunt, receive, decode, Ncr gap and transmit.
    always_comb begin
        state_s     = state_r;
        hunt_zero_s = hunt_zero_r;
        bit_cnt_s   = bit_cnt_r;
        rx_sr_s     = rx_sr_r;
        tx_sr_s     = tx_sr_r;
        tx_len_s    = tx_len_r;
        tx_cnt_s    = tx_cnt_r;
        ncr_cnt_s   = ncr_cnt_r;
        poll_cnt_s  = poll_cnt_r;
        spi_mode_s  = spi_mode_r;
        app_flag_s  = app_flag_r;
        in_idle_s   = in_idle_r;
        cmd_valid_s = 1'b0;
        cmd_index_s = cmd_index_r;
        cmd_arg_s   = cmd_arg_r;
        miso_s      = miso_r;
        crc_clr_s   = 1'b0;
        crc_shift_s = 1'b0;
        if (cs_sync_r) begin
            state_s     = S_HUNT;
            hunt_zero_s = 1'b0;
            app_flag_s  = 1'b0;
            miso_s      = 1'b1;
            crc_clr_s   = 1'b1;
        end else begin
            case (state_r)
                S_HUNT: begin
                    miso_s    = 1'b1;
                    // Clearing until a 0 is seen also yields the CRC of that start bit.
                    crc_clr_s = ~hunt_zero_r;
                    if (rise_s) begin
                        if (!cmd_sync_r) begin
                            hunt_zero_s = 1'b1;
                        end else if (hunt_zero_r) begin
                            crc_shift_s = 1'b1;
                            hunt_zero_s = 1'b0;
                            bit_cnt_s   = 6'd2;
                            rx_sr_s     = {46'd0, 2'b01};
                            state_s     = S_RX;
                        end else begin
                            hunt_zero_s = 1'b0;
                        end
                    end else begin
                        hunt_zero_s = hunt_zero_r;
                    end
                end
                S_RX: begin
                    if (rise_s) begin
                        rx_sr_s     = {rx_sr_r[46:0], cmd_sync_r};
                        crc_shift_s = (bit_cnt_r < 6'd40);
                        bit_cnt_s   = bit_cnt_r + 6'd1;
                        if (bit_cnt_r == (FRAME_W - 6'd1)) begin
                            state_s = S_DECODE;
                        end else begin
                            state_s = S_RX;
                        end
                    end else begin
                        state_s = S_RX;
                    end
                end
                S_DECODE: begin
                    state_s     = S_HUNT;
                    hunt_zero_s = 1'b0;
                    ncr_cnt_s   = 6'd0;
                    tx_cnt_s    = 6'd0;
                    if (!frame_ok_s) begin
                        state_s = S_HUNT;
                    end else begin
                        cmd_valid_s = 1'b1;
                        cmd_index_s = frame_idx_s;
                        cmd_arg_s   = frame_arg_s;
                        app_flag_s  = 1'b0;
                        state_s     = S_NCR;
                        tx_len_s    = R1_W;
                        if (!spi_mode_r && (frame_idx_s != CMD0)) begin
                            state_s = S_HUNT;
                        end else if (crc_err_s) begin
                            tx_sr_s = {make_r1(1'b1, 1'b0, in_idle_r), 32'h0};
                        end else if (frame_idx_s == CMD0) begin
                            spi_mode_s = 1'b1;
                            in_idle_s  = 1'b1;
                            poll_cnt_s = POLL_INIT;
                            tx_sr_s    = {make_r1(1'b0, 1'b0, 1'b1), 32'h0};
                        end else if (frame_idx_s == CMD8) begin
                            tx_sr_s  = {make_r1(1'b0, 1'b0, in_idle_r), 16'h0000, 4'h0,
                                        frame_arg_s[11:0]};
                            tx_len_s = R7_W;
                        end else if (frame_idx_s == CMD55) begin
                            app_flag_s = 1'b1;
                            tx_sr_s    = {make_r1(1'b0, 1'b0, in_idle_r), 32'h0};
                        end else if ((frame_idx_s == CMD41) && app_flag_r) begin
                            poll_cnt_s = poll_dec_s;
                            in_idle_s  = acmd_idle_s;
                            tx_sr_s    = {make_r1(1'b0, 1'b0, acmd_idle_s), 32'h0};
                        end else if (frame_idx_s == CMD58) begin
                            tx_sr_s  = {make_r1(1'b0, 1'b0, in_idle_r), ocr_s};
                            tx_len_s = R3_W;
                        end else begin
                            tx_sr_s = {make_r1(1'b0, 1'b1, in_idle_r), 32'h0};
                        end
                    end
                end
                S_NCR: begin
                    miso_s = 1'b1;
                    if (fall_s) begin
                        if (ncr_cnt_r == NCR_LAST) begin
                            state_s = S_TX;
                        end else begin
                            ncr_cnt_s = ncr_cnt_r + 6'd1;
                        end
                    end else begin
                        ncr_cnt_s = ncr_cnt_r;
                    end
                end
                S_TX: begin
                    if (fall_s) begin
                        if (tx_cnt_r == tx_len_r) begin
                            miso_s  = 1'b1;
                            state_s = S_HUNT;
                        end else begin
                            miso_s   = tx_sr_r[39];
                            tx_sr_s  = {tx_sr_r[38:0], 1'b0};
                            tx_cnt_s = tx_cnt_r + 6'd1;
                        end
                    end else begin
                        miso_s = miso_r;
                    end
                end
                default: begin
                    state_s = S_HUNT;
                    miso_s  = 1'b1;
                end
            endcase
        end
    end

    // Register all card state and the host-visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_HUNT;
            hunt_zero_r <= 1'b0;
            bit_cnt_r   <= 6'd0;
            rx_sr_r     <= 48'd0;
            tx_sr_r     <= 40'd0;
            tx_len_r    <= 6'd0;
            tx_cnt_r    <= 6'd0;
            ncr_cnt_r   <= 6'd0;
            poll_cnt_r  <= POLL_INIT;
            spi_mode_r  <= 1'b0;
            app_flag_r  <= 1'b0;
            in_idle_r   <= 1'b1;
            cmd_valid_r <= 1'b0;
            cmd_index_r <= 6'd0;
            cmd_arg_r   <= 32'd0;
            miso_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            hunt_zero_r <= hunt_zero_s;
            bit_cnt_r   <= bit_cnt_s;
            rx_sr_r     <= rx_sr_s;
            tx_sr_r     <= tx_sr_s;
            tx_len_r    <= tx_len_s;
            tx_cnt_r    <= tx_cnt_s;
            ncr_cnt_r   <= ncr_cnt_s;
            poll_cnt_r  <= poll_cnt_s;
            spi_mode_r  <= spi_mode_s;
            app_flag_r  <= app_flag_s;
            in_idle_r   <= in_idle_s;
            cmd_valid_r <= cmd_valid_s;
            cmd_index_r <= cmd_index_s;
            cmd_arg_r   <= cmd_arg_s;
            miso_r      <= miso_s;
        end
    end

    assign sd_data0  = miso_r;
    assign cmd_valid = cmd_valid_r;
    assign cmd_index = cmd_index_r;
    assign cmd_arg   = cmd_arg_r;
    assign in_idle   = in_idle_r;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bit-banged SPI host driving the card responder; expected responses and
// frames are queued at issue time and checked by independent monitors.
module tb_sd_spi_card_responder;

    localparam int NCR = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_cclk = 1'b0;
    logic        sd_cmd = 1'b1;
    logic        sd_cs = 1'b1;
    logic        sd_data0;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        in_idle;

    typedef struct { logic [5:0] idx; logic [31:0] arg; } cmd_t;
    typedef struct { int len; logic [39:0] data; int ncr; } rsp_t;

    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];
    rsp_t obs_rsp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic cv_prev = 1'b0;
    cmd_t mon_c;

    sd_spi_card_responder #(
        .NCR_BYTES  (NCR),
        .IDLE_POLLS (2),
        .CHECK_CRC  (1),
        .OCR_READY  (32'hC0FF8000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sd_cclk   (sd_cclk),
        .sd_cmd    (sd_cmd),
        .sd_cs     (sd_cs),
        .sd_data0  (sd_data0),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .in_idle   (in_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One SPI bit: MOSI set, MISO sampled just before the rising edge.
    task automatic xfer_bit(input logic tx, output logic rx);
        sd_cmd = tx;
        #50;
        rx = sd_data0;
        sd_cclk = 1'b1;
        #50;
        sd_cclk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(tx[i], bit_v);
            rx[i] = bit_v;
        end
    endtask

    // Send a frame, queue its expectations, then read the reply.
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crcb,
                            input bit exp_frame, input int exp_len, input logic [39:0] exp_data);
        logic [47:0] frame;
        logic [7:0]  b;
        cmd_t        c;
        rsp_t        e;
        rsp_t        o;
        bit          found;
        frame = {2'b01, idx, arg, crcb};
        if (exp_frame) begin
            c.idx = idx;
            c.arg = arg;
            exp_cmd_q.push_back(c);
        end
        e.len  = exp_len;
        e.data = exp_data;
        e.ncr  = NCR;
        exp_rsp_q.push_back(e);
        for (int i = 5; i >= 0; i--) xfer_byte(frame[i*8 +: 8], b);
        o.len = 0;
        o.data = 40'd0;
        o.ncr = 0;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            xfer_byte(8'hFF, b);
            if (b != 8'hFF) begin
                found  = 1'b1;
                o.ncr  = k;
                o.len  = 1;
                o.data = {32'd0, b};
            end
        end
        if (found) begin
            for (int k = 1; k < exp_len; k++) begin
                xfer_byte(8'hFF, b);
                o.data = {o.data[31:0], b};
                o.len++;
            end
        end
        obs_rsp_q.push_back(o);
        xfer_byte(8'hFF, b);
    endtask

    // Response checker: pairs each observed reply with the oldest expectation.
    initial begin : rsp_checker
        rsp_t e;
        rsp_t o;
        forever begin
            while (obs_rsp_q.size() == 0) @(negedge clk);
            o = obs_rsp_q.pop_front();
            if (exp_rsp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: actual len=%0d required=none", o.len);
            end else begin
                e = exp_rsp_q.pop_front();
                check("rsp_len", 64'(o.len), 64'(e.len));
                if (e.len > 0) begin
                    check("rsp_data", {24'd0, o.data}, {24'd0, e.data});
                    check("rsp_ncr_bytes", 64'(o.ncr), 64'(e.ncr));
                end
            end
        end
    end

    // Frame monitor: every cmd_valid pulse must match a queued frame and last one clk.
    always @(negedge clk) begin
        if (cmd_valid) begin
            if (exp_cmd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL cmd_unexpected: actual index=%0d arg=0x%0h required=no frame",
                         cmd_index, cmd_arg);
            end else begin
                mon_c = exp_cmd_q.pop_front();
                check("cmd_index", 64'(cmd_index), 64'(mon_c.idx));
                check("cmd_arg", 64'(cmd_arg), 64'(mon_c.arg));
            end
            check("cmd_valid_pulse", 64'(cv_prev), 64'(0));
        end
        cv_prev <= cmd_valid;
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] b;
        logic       bit_v;
        #32;
        @(negedge clk);
        check("rst_miso", 64'(sd_data0), 64'(1));
        check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rst_cmd_index", 64'(cmd_index), 64'(0));
        check("rst_cmd_arg", 64'(cmd_arg), 64'(0));
        check("rst_in_idle", 64'(in_idle), 64'(1));
        rst_n = 1'b1;
        #100;
        sd_cs = 1'b0;
        #100;
        xfer_byte(8'hFF, b);

        // Before CMD0 the card stays silent but still reports the frame.
        send_cmd(6'd8, 32'h000001AA, 8'h87, 1'b1, 0, 40'h0);
        send_cmd(6'd0, 32'h0, 8'h95, 1'b1, 1, 40'h01);
        send_cmd(6'd8, 32'h000001AA, 8'h87, 1'b1, 5, 40'h01000001AA);
        // 0x94 carries end bit 0, so the frame is dropped outright.
        send_cmd(6'd0, 32'h0, 8'h94, 1'b0, 0, 40'h0);
        // 0x97 keeps the end bit but breaks the CRC7 field.
        send_cmd(6'd0, 32'h0, 8'h97, 1'b1, 1, 40'h09);
        send_cmd(6'd0, 32'h0, 8'h95, 1'b1, 1, 40'h01);
        send_cmd(6'd58, 32'h0, 8'hFD, 1'b1, 5, 40'h0140FF8000);
        send_cmd(6'd55, 32'h0, 8'h65, 1'b1, 1, 40'h01);
        send_cmd(6'd41, 32'h40000000, 8'h77, 1'b1, 1, 40'h01);
        check("idle_after_acmd41_1", 64'(in_idle), 64'(1));
        send_cmd(6'd55, 32'h0, 8'h65, 1'b1, 1, 40'h01);
        send_cmd(6'd41, 32'h40000000, 8'h77, 1'b1, 1, 40'h00);
        check("idle_after_acmd41_2", 64'(in_idle), 64'(0));
        send_cmd(6'd58, 32'h0, 8'hFD, 1'b1, 5, 40'h00C0FF8000);
        send_cmd(6'd17, 32'h0, 8'h01, 1'b1, 1, 40'h04);
        send_cmd(6'd41, 32'h40000000, 8'h77, 1'b1, 1, 40'h04);
        send_cmd(6'd17, 32'h0, 8'h00, 1'b0, 0, 40'h0);

        // Abort a CMD0 after 20 bits by deselecting the card.
        xfer_byte(8'h40, b);
        xfer_byte(8'h00, b);
        check("abort_miso_rx", 64'(b), 64'hFF);
        for (int i = 0; i < 4; i++) xfer_bit(1'b0, bit_v);
        sd_cs = 1'b1;
        #200;
        check("abort_miso", 64'(sd_data0), 64'(1));
        xfer_byte(8'h00, b);
        check("cs_high_miso", 64'(b), 64'hFF);
        check("abort_idle_kept", 64'(in_idle), 64'(0));
        sd_cs = 1'b0;
        #100;
        xfer_byte(8'hFF, b);
        send_cmd(6'd0, 32'h0, 8'h95, 1'b1, 1, 40'h01);
        check("idle_after_cmd0", 64'(in_idle), 64'(1));

        // Deselecting between CMD55 and CMD41 drops the application prefix.
        send_cmd(6'd55, 32'h0, 8'h65, 1'b1, 1, 40'h01);
        sd_cs = 1'b1;
        #200;
        sd_cs = 1'b0;
        #100;
        send_cmd(6'd41, 32'h40000000, 8'h77, 1'b1, 1, 40'h05);

        #2000;
        check("exp_rsp_left", 64'(exp_rsp_q.size()), 64'(0));
        check("exp_cmd_left", 64'(exp_cmd_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
